// File: rtl/dc_remove_mc.sv
// dc_remove_mc: multi-channel DC-offset removal with window calibration,
// optional leaky-integrator tracking, programmable gain and saturation.
module dc_remove_mc #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned LOG2_ACC    = 11,
  parameter int unsigned TRACK_SHIFT = 8,
  parameter int unsigned MAX_SHIFT   = 3,
  localparam int unsigned GW = (MAX_SHIFT < 1) ? 1 : $clog2(MAX_SHIFT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      calibrate,
  input  logic                      track_en,
  input  logic [GW-1:0]             gain_shift,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      cal_done
);

  localparam int unsigned ACC_W = WIDTH + LOG2_ACC;
  localparam int unsigned OFF_W = WIDTH + TRACK_SHIFT + 1;
  localparam int unsigned EFF_W = WIDTH + 1;
  localparam int unsigned DIF_W = WIDTH + 2;
  localparam int unsigned SH_W  = DIF_W + MAX_SHIFT;

  localparam logic signed [SH_W-1:0] SAT_HI = SH_W'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [SH_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD, TRACK} state_t;

  state_t                     state;
  logic [LOG2_ACC-1:0]        cnt;
  logic signed [ACC_W-1:0]    acc      [CHANNELS];
  // off_q always holds the offset scaled by 2^TRACK_SHIFT, so the same
  // effective-offset path serves IDLE, HOLD and TRACK
  logic signed [OFF_W-1:0]    off_q    [CHANNELS];

  logic [GW-1:0]              gain_c;
  logic signed [WIDTH-1:0]    x        [CHANNELS];
  logic signed [EFF_W-1:0]    eff      [CHANNELS];
  logic signed [DIF_W-1:0]    diff     [CHANNELS];
  logic signed [SH_W-1:0]     shv      [CHANNELS];
  logic [WIDTH-1:0]           sat      [CHANNELS];
  logic signed [ACC_W-1:0]    acc_sum  [CHANNELS];
  logic signed [WIDTH-1:0]    cal_off  [CHANNELS];
  logic signed [OFF_W-1:0]    off_trk  [CHANNELS];
  logic signed [OFF_W-1:0]    off_load [CHANNELS];

  // Per-channel datapath: subtract, shift, saturate; plus accumulator/tracker next values
  always_comb begin
    gain_c = (gain_shift > GW'(MAX_SHIFT)) ? GW'(MAX_SHIFT) : gain_shift;
    for (int c = 0; c < CHANNELS; c++) begin
      x[c]    = in_data[c*WIDTH +: WIDTH];
      eff[c]  = EFF_W'(off_q[c] >>> TRACK_SHIFT);
      diff[c] = DIF_W'(x[c]) - DIF_W'(eff[c]);
      shv[c]  = SH_W'(diff[c]) <<< gain_c;
      if (shv[c] > SAT_HI) begin
        sat[c] = SAT_HI[WIDTH-1:0];
      end else if (shv[c] < SAT_LO) begin
        sat[c] = SAT_LO[WIDTH-1:0];
      end else begin
        sat[c] = shv[c][WIDTH-1:0];
      end
      acc_sum[c]  = acc[c] + ACC_W'(x[c]);
      cal_off[c]  = WIDTH'(acc_sum[c] >>> LOG2_ACC);
      off_trk[c]  = off_q[c] + OFF_W'(x[c]) - (off_q[c] >>> TRACK_SHIFT);
      off_load[c] = OFF_W'(cal_off[c]) <<< TRACK_SHIFT;
    end
  end

  // Control FSM, accumulators, offsets and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      cal_done  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc[c]   <= '0;
        off_q[c] <= '0;
      end
    end else begin
      cal_done  <= 1'b0;
      out_valid <= in_valid;
      if (in_valid) begin
        for (int c = 0; c < CHANNELS; c++) begin
          out_data[c*WIDTH +: WIDTH] <= sat[c];
        end
      end

      case (state)
        IDLE, HOLD: begin
          if (calibrate) begin
            state <= ACCUM;
            busy  <= 1'b1;
            cnt   <= '0;
            for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
          end
        end
        ACCUM: begin
          if (calibrate) begin
            // restart the window; the offset in use is left untouched
            cnt <= '0;
            for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
          end else if (in_valid) begin
            if (cnt == '1) begin
              cnt      <= '0;
              cal_done <= 1'b1;
              busy     <= 1'b0;
              state    <= track_en ? TRACK : HOLD;
              for (int c = 0; c < CHANNELS; c++) begin
                acc[c]   <= '0;
                off_q[c] <= off_load[c];
              end
            end else begin
              cnt <= cnt + LOG2_ACC'(1);
              for (int c = 0; c < CHANNELS; c++) acc[c] <= acc_sum[c];
            end
          end
        end
        TRACK: begin
          if (calibrate) begin
            state <= ACCUM;
            busy  <= 1'b1;
            cnt   <= '0;
            for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
          end else if (in_valid) begin
            for (int c = 0; c < CHANNELS; c++) off_q[c] <= off_trk[c];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_remove_mc.sv
// tb_dc_remove_mc: randomized and directed checks against a behavioural model.
module tb_dc_remove_mc;

  localparam int W = 16;
  localparam int N = 16;   // calibration window with LOG2_ACC=4
  localparam int T = 16;   // tracking divisor with TRACK_SHIFT=4

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [2*W-1:0] in_data = '0;
  logic          calibrate = 1'b0;
  logic          track_en = 1'b0;
  logic [1:0]    gain_shift = '0;
  logic          out_valid;
  logic [2*W-1:0] out_data;
  logic          busy;
  logic          cal_done;

  dc_remove_mc #(
    .WIDTH(16), .CHANNELS(2), .LOG2_ACC(4), .TRACK_SHIFT(4), .MAX_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .calibrate(calibrate), .track_en(track_en), .gain_shift(gain_shift),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  bit     m_cal = 0;
  bit     m_trk = 0;
  int     m_n = 0;
  longint m_sum [2] = '{0, 0};
  int     m_off [2] = '{0, 0};
  longint m_tq  [2] = '{0, 0};
  int     e_v = 0, e_busy = 0, e_cd = 0;
  int     e_d [2] = '{0, 0};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int eff_off(input int c);
    return m_trk ? int'(fdiv(m_tq[c], T)) : m_off[c];
  endfunction

  function automatic int sat_ref(input int x, input int off, input int g);
    longint v;
    v = longint'(x - off) * (longint'(1) << g);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  function automatic int ch(input int c);
    logic [W-1:0] s;
    s = out_data[c*W +: W];
    return int'($signed(s));
  endfunction

  task automatic model_step(input bit r, input bit v, input int d0, input int d1,
                            input bit cal, input bit trk, input int g);
    int d [2];
    d[0] = d0; d[1] = d1;
    if (r) begin
      m_cal = 0; m_trk = 0; m_n = 0;
      for (int c = 0; c < 2; c++) begin m_sum[c] = 0; m_off[c] = 0; m_tq[c] = 0; e_d[c] = 0; end
      e_v = 0; e_busy = 0; e_cd = 0;
      return;
    end
    e_cd = 0;
    e_v  = int'(v);
    if (v) for (int c = 0; c < 2; c++) e_d[c] = sat_ref(d[c], eff_off(c), g);
    if (cal) begin
      m_cal = 1; m_n = 0;
      m_sum[0] = 0; m_sum[1] = 0;
    end else if (m_cal && v) begin
      for (int c = 0; c < 2; c++) m_sum[c] += d[c];
      m_n++;
      if (m_n == N) begin
        for (int c = 0; c < 2; c++) begin
          m_off[c] = int'(fdiv(m_sum[c], N));
          m_tq[c]  = longint'(m_off[c]) * T;
          m_sum[c] = 0;
        end
        m_n = 0; m_cal = 0; m_trk = trk; e_cd = 1;
      end
    end else if (!m_cal && m_trk && v) begin
      for (int c = 0; c < 2; c++) m_tq[c] = m_tq[c] + d[c] - fdiv(m_tq[c], T);
    end
    e_busy = int'(m_cal);
  endtask

  // Check last cycle's result, then drive the next inputs and advance the model
  task automatic cycle(input bit r, input bit v, input int d0, input int d1,
                       input bit cal, input bit trk, input int g);
    @(negedge clk);
    chk("out_valid", int'(out_valid), e_v);
    chk("out_ch0", ch(0), e_d[0]);
    chk("out_ch1", ch(1), e_d[1]);
    chk("busy", int'(busy), e_busy);
    chk("cal_done", int'(cal_done), e_cd);
    rst = r; in_valid = v; calibrate = cal; track_en = trk;
    in_data = {W'(d1), W'(d0)};
    gain_shift = 2'(g);
    model_step(r, v, d0, d1, cal, trk, g);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int prev, cur;
    bit mono;
    int k;
    model_step(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    // Passthrough before any calibration
    cycle(0, 1, 1000, -1000, 0, 0, 0);
    idle();
    chk("raw_ch0", ch(0), 1000);
    chk("raw_ch1", ch(1), -1000);
    chk("raw_busy", int'(busy), 0);

    // Constant calibration, hold mode
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < N; i++) cycle(0, 1, 100, -50, 0, 0, 0);
    idle();
    chk("cal_pulse", int'(cal_done), 1);
    cycle(0, 1, 100, -50, 0, 0, 0);
    idle();
    chk("cal_zero0", ch(0), 0);
    chk("cal_zero1", ch(1), 0);
    cycle(0, 1, 200, -50, 0, 0, 2);
    idle();
    chk("gain2", ch(0), 400);

    // Saturation
    cycle(0, 1, -32768, 0, 0, 0, 0);
    idle();
    chk("sat_neg0", ch(0), -32768);
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < N; i++) cycle(0, 1, -100, 50, 0, 0, 0);
    cycle(0, 1, 32000, 0, 0, 0, 3);
    idle();
    chk("sat_pos0", ch(0), 32767);
    cycle(0, 1, 0, -32000, 0, 0, 1);
    idle();
    chk("sat_neg1", ch(1), -32768);

    // Valid gaps during calibration, ch0 alternating 0/7
    cycle(0, 0, 0, 0, 1, 0, 0);
    k = 0;
    while (k < N) begin
      if ($urandom_range(0, 2) == 0) idle();
      else begin
        cycle(0, 1, (k % 2) * 7, int'($urandom_range(0, 2000)) - 1000, 0, 0, 0);
        k++;
      end
    end
    cycle(0, 1, 7, 0, 0, 0, 0);
    idle();
    chk("gap_off", ch(0), 4);

    // Restart after 10 samples, then a completing sample that collides with calibrate
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, int'($urandom_range(0, 400)), -7, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < N - 1; i++) cycle(0, 1, int'($urandom_range(0, 400)), 9, 0, 0, 0);
    cycle(0, 1, 5, 5, 1, 0, 0);
    for (int i = 0; i < N; i++) cycle(0, 1, int'($urandom_range(0, 400)), 11, 0, 0, 0);
    idle();
    chk("restart_done", int'(cal_done), 1);

    // Reset mid-accumulation returns to raw passthrough
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 500, 500, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 321, -123, 0, 0, 0);
    idle();
    chk("rst_busy", int'(busy), 0);
    chk("rst_raw0", ch(0), 321);
    chk("rst_raw1", ch(1), -123);

    // Tracking from a zero calibration toward a constant 160
    cycle(0, 0, 0, 0, 1, 1, 0);
    for (int i = 0; i < N; i++) cycle(0, 1, 0, 0, 0, 1, 0);
    mono = 1;
    prev = 32767;
    for (int i = 0; i < 200; i++) begin
      cycle(0, 1, 160, 0, 0, 1, 0);
      if (i >= 2) begin
        cur = ch(0);
        if (cur > prev) mono = 0;
        prev = cur;
      end
    end
    idle();
    chk("trk_mono", int'(mono), 1);
    chk("trk_conv", int'(ch(0) >= -1 && ch(0) <= 1), 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit v, cal, r;
      v   = ($urandom_range(0, 3) != 0);
      cal = !v && ($urandom_range(0, 40) == 0);
      r   = ($urandom_range(0, 500) == 0);
      cycle(r, v, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768,
            cal, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
